// File: rtl/axi4_slave_pkg.sv
// Shared types for the AXI4 slave memory path.
// Arbiter state encoding and port identifiers.
package axi4_slave_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_RD_LOCK = 2'b01,
    ARB_WR_LOCK = 2'b10
  } arb_state_t;

  localparam logic ARB_PORT_WR = 1'b0;
  localparam logic ARB_PORT_RD = 1'b1;

endpackage

// File: rtl/axi4_slave_mem_arbiter.sv
// Per-beat, burst-locked round-robin arbiter for the slave's
// single-port memory, with an idle watchdog on the lock owner.
module axi4_slave_mem_arbiter
  import axi4_slave_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int IDLE_TIMEOUT   = 16,
  parameter int RESET_PRIORITY = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_last,
  output logic                    rd_gnt,
  output logic                    rd_rvalid,
  output logic [DATA_WIDTH-1:0]   rd_rdata,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_wdata,
  input  logic [DATA_WIDTH/8-1:0] wr_wstrb,
  input  logic                    wr_last,
  output logic                    wr_gnt,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    timeout_err
);

  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_TIMEOUT - 1);
  localparam logic LW_RST = (RESET_PRIORITY != 0);

  arb_state_t    state_q, state_d;
  logic          lw_q, lw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;

  always_comb begin
    rd_gnt      = 1'b0;
    wr_gnt      = 1'b0;
    state_d     = state_q;
    lw_d        = lw_q;
    cnt_d       = cnt_q;
    timeout_err = 1'b0;
    // rst gating keeps grants low while reset is held
    unique case (state_q)
      ARB_IDLE: begin
        if (rd_req && (!wr_req || lw_q == ARB_PORT_WR))
          rd_gnt = rst;
        else if (wr_req)
          wr_gnt = rst;
      end
      ARB_RD_LOCK: rd_gnt = rd_req & rst;
      ARB_WR_LOCK: wr_gnt = wr_req & rst;
      default: ;
    endcase
    if (rd_gnt) begin
      cnt_d = '0;
      if (rd_last) begin
        state_d = ARB_IDLE;
        lw_d    = ARB_PORT_RD;
      end else begin
        state_d = ARB_RD_LOCK;
      end
    end else if (wr_gnt) begin
      cnt_d = '0;
      if (wr_last) begin
        state_d = ARB_IDLE;
        lw_d    = ARB_PORT_WR;
      end else begin
        state_d = ARB_WR_LOCK;
      end
    end else if (state_q != ARB_IDLE) begin
      // no grant while locked means the owner left req low
      if (cnt_q == CNT_LAST) begin
        state_d     = ARB_IDLE;
        cnt_d       = '0;
        timeout_err = 1'b1;
        lw_d        = (state_q == ARB_RD_LOCK) ? ARB_PORT_RD
                                               : ARB_PORT_WR;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    rvalid_d = rd_gnt & ~wr_gnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      lw_q     <= LW_RST;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lw_q     <= lw_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign mem_en    = rd_gnt | wr_gnt;
  assign mem_we    = wr_gnt;
  assign mem_addr  = wr_gnt ? wr_addr : rd_addr;
  assign mem_wdata = wr_wdata;
  assign mem_wstrb = wr_gnt ? wr_wstrb : '0;
  assign rd_rvalid = rvalid_q;
  assign rd_rdata  = mem_rdata;

endmodule

// File: tb/tb_axi4_slave_mem_arbiter.sv
// Bench for axi4_slave_mem_arbiter: vector table, corner
// sequences and a randomized run against a burst-owner model.
module tb_axi4_slave_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, rd_last, rd_gnt, rd_rvalid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_rdata;
  logic          wr_req, wr_last, wr_gnt;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wdata;
  logic [3:0]    wr_wstrb;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
  logic          timeout_err;

  always #5 clk = ~clk;

  axi4_slave_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .IDLE_TIMEOUT(TO), .RESET_PRIORITY(0)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last),
    .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata),
    .wr_wstrb(wr_wstrb), .wr_last(wr_last), .wr_gnt(wr_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  typedef struct {
    bit          rq, rl, wq, wl;
    logic [31:0] ra, wa;
    logic [3:0]  ws;
    bit          erg, ewg, et;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  bit prev_rg = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(bit rq, bit rl, bit wq, bit wl,
                              bit erg, bit ewg, bit et,
                              logic [31:0] ra = 32'h0,
                              logic [31:0] wa = 32'h0,
                              logic [3:0] ws = 4'hF);
    vec_t v;
    v.rq = rq; v.rl = rl; v.wq = wq; v.wl = wl;
    v.ra = ra; v.wa = wa; v.ws = ws;
    v.erg = erg; v.ewg = ewg; v.et = et;
    return v;
  endfunction

  task automatic cyc(input vec_t v, input string nm);
    logic [DW-1:0] wd, md;
    @(negedge clk);
    wd = $urandom; md = $urandom;
    rd_req = v.rq; rd_last = v.rl; rd_addr = v.ra;
    wr_req = v.wq; wr_last = v.wl; wr_addr = v.wa;
    wr_wstrb = v.ws; wr_wdata = wd; mem_rdata = md;
    #1;
    chk({nm, "_ctl"},
        64'({rd_gnt, wr_gnt, timeout_err, rd_rvalid}),
        64'({v.erg, v.ewg, v.et, prev_rg}));
    chk({nm, "_en_we"}, 64'({mem_en, mem_we}),
        64'({v.erg | v.ewg, v.ewg}));
    if (v.erg | v.ewg)
      chk({nm, "_addr"}, 64'(mem_addr), 64'(v.ewg ? v.wa : v.ra));
    chk({nm, "_wstrb"}, 64'(mem_wstrb), 64'(v.ewg ? v.ws : 4'h0));
    chk({nm, "_data"}, {mem_wdata, rd_rdata}, {wd, md});
    prev_rg = v.erg;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1;
    #2;
    chk("reset_outs",
        64'({rd_gnt, wr_gnt, mem_en, rd_rvalid, timeout_err}), 64'(0));
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    rst = 1'b1;
    prev_rg = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    bit m_locked, m_lock_rd, m_last_rd;
    int m_stall;

    rst = 1'b0;
    rd_req = 0; rd_last = 0; rd_addr = '0;
    wr_req = 0; wr_last = 0; wr_addr = '0;
    wr_wdata = '0; wr_wstrb = '0; mem_rdata = '0;
    do_reset();

    // contention after reset: read wins, write follows with no bubble
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 32'h00, 32'h100));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 32'h04, 32'h100));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 32'h08, 32'h100));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 32'h0C, 32'h100));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 32'h10, 32'h100));
    tbl.push_back(mk(1, 0, 1, 1, 0, 1, 0, 32'h10, 32'h104));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h108));
    // single-beat bursts, both ports always requesting
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 32'h20, 32'h200, 4'h3));
    tbl.push_back(mk(1, 1, 1, 1, 0, 1, 0, 32'h24, 32'h204, 4'h5));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 32'h28, 32'h208, 4'hC));
    tbl.push_back(mk(1, 1, 1, 1, 0, 1, 0, 32'h2C, 32'h20C, 4'h1));
    foreach (tbl[i]) cyc(tbl[i], $sformatf("vec%0d", i));

    // write owner drops req for 3 cycles, read must wait
    cyc(mk(0, 0, 1, 0, 0, 1, 0, $urandom, $urandom), "stall_w0");
    for (int i = 0; i < 3; i++)
      cyc(mk(1, 0, 0, 0, 0, 0, 0, $urandom, $urandom), "stall_gap");
    cyc(mk(1, 0, 1, 1, 0, 1, 0, $urandom, $urandom), "stall_w1");
    cyc(mk(1, 1, 0, 0, 1, 0, 0, $urandom, $urandom), "stall_rd");

    // owner idles for TO cycles: force release, read next
    cyc(mk(0, 0, 1, 0, 0, 1, 0, $urandom, $urandom), "to_w0");
    for (int i = 0; i < TO - 1; i++)
      cyc(mk(1, 0, 0, 0, 0, 0, 0, $urandom, $urandom), "to_wait");
    cyc(mk(1, 0, 0, 0, 0, 0, 1, $urandom, $urandom), "to_fire");
    cyc(mk(1, 1, 0, 0, 1, 0, 0, $urandom, $urandom), "to_rd");

    // reset during beat 2 of a read burst
    cyc(mk(1, 0, 0, 0, 1, 0, 0, 32'h40), "mrst_b1");
    cyc(mk(1, 0, 0, 0, 1, 0, 0, 32'h44), "mrst_b2");
    rst = 1'b0;
    #1;
    chk("mrst_outs", 64'({rd_gnt, mem_en, rd_rvalid}), 64'(0));
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    rst = 1'b1;
    prev_rg = 1'b0;
    cyc(mk(0, 0, 1, 1, 0, 1, 0, 32'h0, 32'h300), "mrst_wr");

    // randomized traffic against a burst-owner model
    do_reset();
    m_locked = 0; m_lock_rd = 0; m_last_rd = 0; m_stall = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rq, rl, wq, wl, erg, ewg, et, sparse;
      sparse = ((i / 40) % 3) == 2;
      rq = sparse ? ($urandom_range(0, 5) == 0)
                  : ($urandom_range(0, 3) != 0);
      wq = sparse ? ($urandom_range(0, 5) == 0)
                  : ($urandom_range(0, 3) != 0);
      rl = $urandom_range(0, 2) == 0;
      wl = $urandom_range(0, 2) == 0;
      erg = 0; ewg = 0;
      if (!m_locked) begin
        if (rq && (!wq || !m_last_rd)) erg = 1;
        else if (wq) ewg = 1;
      end else if (m_lock_rd) begin
        erg = rq;
      end else begin
        ewg = wq;
      end
      et = m_locked && !(erg || ewg) && (m_stall == TO - 1);
      cyc(mk(rq, rl, wq, wl, erg, ewg, et, $urandom, $urandom,
             4'($urandom)), "rand");
      if (erg || ewg) begin
        m_stall = 0;
        if (erg ? rl : wl) begin
          m_locked = 0;
          m_last_rd = erg;
        end else begin
          m_locked = 1;
          m_lock_rd = erg;
        end
      end else if (m_locked) begin
        if (et) begin
          m_locked = 0;
          m_last_rd = m_lock_rd;
          m_stall = 0;
        end else begin
          m_stall++;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
